// File: rtl/bitmap_ram_sched_if.sv
// Bus bundle between ingest/query clients, the bitmap RAM scheduler and the RAM.
// The slave side is the scheduler; the master side is the clients plus the RAM.
interface bitmap_ram_sched_if #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_REQ    = 2
);
    localparam int unsigned MAP_W = 2 ** ADDR_WIDTH;

    logic [NUM_REQ-1:0]            wr_valid;
    logic [NUM_REQ-1:0]            wr_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] wr_val;
    logic                          q_valid;
    logic                          q_ready;
    logic [DATA_WIDTH-1:0]         q_val;
    logic                          rsp_valid;
    logic [MAP_W-1:0]              rsp_map;
    logic [ADDR_WIDTH:0]           rsp_count;
    logic                          clr_req;
    logic                          clr_done;
    logic                          busy;
    logic                          ram_rst;
    logic                          ram_write;
    logic [ADDR_WIDTH-1:0]         ram_a_addr;
    logic [DATA_WIDTH-1:0]         ram_a_din;
    logic [DATA_WIDTH-1:0]         ram_b_din;
    logic [MAP_W-1:0]              ram_b_dout;

    modport slave (
        input  wr_valid, wr_addr, wr_val, q_valid, q_val, clr_req, ram_b_dout,
        output wr_ready, q_ready, rsp_valid, rsp_map, rsp_count, clr_done, busy,
               ram_rst, ram_write, ram_a_addr, ram_a_din, ram_b_din
    );

    modport master (
        output wr_valid, wr_addr, wr_val, q_valid, q_val, clr_req, ram_b_dout,
        input  wr_ready, q_ready, rsp_valid, rsp_map, rsp_count, clr_done, busy,
               ram_rst, ram_write, ram_a_addr, ram_a_din, ram_b_din
    );
endinterface

// File: rtl/bitmap_ram_sched.sv
// Arbitrates writers, one query client and clear onto the dual-port presence-bitmap RAM,
// registering all RAM controls so the RAM samples them on the following negedge.
module bitmap_ram_sched #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic               clk,
    input  logic               rst,
    bitmap_ram_sched_if.slave  bus
);
    localparam int unsigned MAP_W = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RD_WAIT, ST_CLEAR} state_t;

    state_t                r_state;
    logic [RR_W-1:0]       r_rr;
    logic                  r_last_q;
    logic                  r_ram_rst;
    logic                  r_ram_write;
    logic [ADDR_WIDTH-1:0] r_ram_a_addr;
    logic [DATA_WIDTH-1:0] r_ram_a_din;
    logic [DATA_WIDTH-1:0] r_ram_b_din;
    logic                  r_rsp_valid;
    logic [MAP_W-1:0]      r_rsp_map;
    logic [CNT_W-1:0]      r_rsp_count;
    logic                  r_clr_done;

    state_t                w_state_nxt;
    logic [RR_W-1:0]       w_rr_nxt;
    logic                  w_last_q_nxt;
    logic                  w_ram_rst_nxt;
    logic                  w_ram_write_nxt;
    logic [ADDR_WIDTH-1:0] w_a_addr_nxt;
    logic [DATA_WIDTH-1:0] w_a_din_nxt;
    logic [DATA_WIDTH-1:0] w_b_din_nxt;
    logic                  w_rsp_valid_nxt;
    logic [MAP_W-1:0]      w_rsp_map_nxt;
    logic [CNT_W-1:0]      w_rsp_count_nxt;
    logic                  w_clr_done_nxt;
    logic [NUM_REQ-1:0]    w_wr_ready;
    logic                  w_q_ready;

    logic [ADDR_WIDTH-1:0] w_addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_val_arr  [NUM_REQ];
    logic                  w_gnt_found;
    logic [RR_W-1:0]       w_gnt_idx;
    logic [RR_W-1:0]       w_cand;
    logic [CNT_W-1:0]      w_popcnt;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi] = bus.wr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_val_arr[gi]  = bus.wr_val[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin pick: scan downward so the smallest offset from r_rr wins.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            w_cand = RR_W'((int'(r_rr) + k) % int'(NUM_REQ));
            if (bus.wr_valid[w_cand]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_popcnt = '0;
        for (int b = 0; b < int'(MAP_W); b++) begin
            w_popcnt = w_popcnt + CNT_W'(bus.ram_b_dout[b]);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_nxt        = r_rr;
        w_last_q_nxt    = r_last_q;
        w_ram_rst_nxt   = 1'b0;
        w_ram_write_nxt = 1'b0;
        w_a_addr_nxt    = r_ram_a_addr;
        w_a_din_nxt     = r_ram_a_din;
        w_b_din_nxt     = r_ram_b_din;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_map_nxt   = r_rsp_map;
        w_rsp_count_nxt = r_rsp_count;
        w_clr_done_nxt  = 1'b0;
        w_wr_ready      = '0;
        w_q_ready       = 1'b0;
        case (r_state)
            ST_INIT: w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                // A query loses its slot only right after another query with writers waiting.
                if (bus.clr_req) begin
                    w_state_nxt   = ST_CLEAR;
                    w_ram_rst_nxt = 1'b1;
                end else if (bus.q_valid && !(r_last_q && (|bus.wr_valid))) begin
                    w_q_ready    = 1'b1;
                    w_b_din_nxt  = bus.q_val;
                    w_last_q_nxt = 1'b1;
                    w_state_nxt  = ST_RD_WAIT;
                end else if (w_gnt_found) begin
                    w_wr_ready[w_gnt_idx] = 1'b1;
                    w_ram_write_nxt       = 1'b1;
                    w_a_addr_nxt          = w_addr_arr[w_gnt_idx];
                    w_a_din_nxt           = w_val_arr[w_gnt_idx];
                    w_rr_nxt              = RR_W'((int'(w_gnt_idx) + 1) % int'(NUM_REQ));
                    w_last_q_nxt          = 1'b0;
                end
            end
            ST_RD_WAIT: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_map_nxt   = bus.ram_b_dout;
                w_rsp_count_nxt = w_popcnt;
                w_state_nxt     = ST_IDLE;
            end
            ST_CLEAR: begin
                w_clr_done_nxt = 1'b1;
                w_state_nxt    = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_rr         <= '0;
            r_last_q     <= 1'b0;
            r_ram_rst    <= 1'b1;
            r_ram_write  <= 1'b0;
            r_ram_a_addr <= '0;
            r_ram_a_din  <= '0;
            r_ram_b_din  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_map    <= '0;
            r_rsp_count  <= '0;
            r_clr_done   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr         <= w_rr_nxt;
            r_last_q     <= w_last_q_nxt;
            r_ram_rst    <= w_ram_rst_nxt;
            r_ram_write  <= w_ram_write_nxt;
            r_ram_a_addr <= w_a_addr_nxt;
            r_ram_a_din  <= w_a_din_nxt;
            r_ram_b_din  <= w_b_din_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_map    <= w_rsp_map_nxt;
            r_rsp_count  <= w_rsp_count_nxt;
            r_clr_done   <= w_clr_done_nxt;
        end
    end

    assign bus.wr_ready   = w_wr_ready;
    assign bus.q_ready    = w_q_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_map    = r_rsp_map;
    assign bus.rsp_count  = r_rsp_count;
    assign bus.clr_done   = r_clr_done;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.ram_rst    = r_ram_rst;
    assign bus.ram_write  = r_ram_write;
    assign bus.ram_a_addr = r_ram_a_addr;
    assign bus.ram_a_din  = r_ram_a_din;
    assign bus.ram_b_din  = r_ram_b_din;
endmodule

// File: tb/tb_bitmap_ram_sched.sv
// Directed bench for bitmap_ram_sched with a behavioural negedge bitmap RAM attached.
module tb_bitmap_ram_sched;
    localparam int unsigned DW    = 4;
    localparam int unsigned AW    = 4;
    localparam int unsigned NR    = 2;
    localparam int unsigned MAP_W = 2 ** AW;
    localparam int unsigned ROWS  = 2 ** DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    bitmap_ram_sched_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();

    bitmap_ram_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // RAM: clear or set one bit, then read row b_din, all on the falling edge.
    logic [MAP_W-1:0] mem [ROWS];
    always @(negedge clk) begin
        if (bus.ram_rst) begin
            for (int r = 0; r < int'(ROWS); r++) mem[r] <= '0;
        end else if (bus.ram_write) begin
            mem[bus.ram_a_din][bus.ram_a_addr] <= 1'b1;
        end
        bus.ram_b_dout <= mem[bus.ram_b_din];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_write(input int req, input int addr, input int val);
        bus.wr_valid             = '0;
        bus.wr_valid[req]        = 1'b1;
        bus.wr_addr[req*AW +: AW] = AW'(addr);
        bus.wr_val[req*DW +: DW]  = DW'(val);
        #1;
        check_eq("wr_ready_grant", 32'(bus.wr_ready), 32'(1) << req);
        tick();
        bus.wr_valid = '0;
        #1;
        check_eq("wr_ram_write", 32'(bus.ram_write), 32'd1);
        check_eq("wr_ram_a_addr", 32'(bus.ram_a_addr), 32'(addr));
        check_eq("wr_ram_a_din", 32'(bus.ram_a_din), 32'(val));
        tick();
        #1;
        check_eq("wr_ram_write_off", 32'(bus.ram_write), 32'd0);
    endtask

    task automatic do_query(input int val, input int exp_map, input int exp_cnt);
        bus.q_val   = DW'(val);
        bus.q_valid = 1'b1;
        #1;
        check_eq("q_ready", 32'(bus.q_ready), 32'd1);
        tick();
        bus.q_valid = 1'b0;
        #1;
        check_eq("q_rdwait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("q_rdwait_busy", 32'(bus.busy), 32'd1);
        tick();
        #1;
        check_eq("q_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check_eq("q_rsp_map", 32'(bus.rsp_map), 32'(exp_map));
        check_eq("q_rsp_count", 32'(bus.rsp_count), 32'(exp_cnt));
        tick();
        #1;
        check_eq("q_rsp_valid_pulse", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int addrs [3];
        int exp_map;
        addrs = '{0, 6, 11};

        bus.wr_valid = '0;
        bus.wr_addr  = '0;
        bus.wr_val   = '0;
        bus.q_valid  = 1'b1;
        bus.q_val    = DW'(3);
        bus.clr_req  = 1'b0;

        // Reset and INIT
        tick();
        tick();
        #1;
        check_eq("rst_ram_rst", 32'(bus.ram_rst), 32'd1);
        check_eq("rst_ram_write", 32'(bus.ram_write), 32'd0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_clr_done", 32'(bus.clr_done), 32'd0);
        check_eq("rst_q_ready", 32'(bus.q_ready), 32'd0);
        check_eq("rst_rsp_count", 32'(bus.rsp_count), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("init_busy", 32'(bus.busy), 32'd1);
        check_eq("init_ram_rst", 32'(bus.ram_rst), 32'd1);
        check_eq("init_q_ready", 32'(bus.q_ready), 32'd0);
        tick();
        #1;
        check_eq("idle_busy", 32'(bus.busy), 32'd0);
        check_eq("idle_ram_rst", 32'(bus.ram_rst), 32'd0);
        do_query(3, 0, 0);

        // Two bits in row 5; neighbouring rows stay empty
        do_write(0, 2, 5);
        do_write(0, 9, 5);
        do_query(5, 16'h0204, 2);
        do_query(4, 0, 0);
        do_query(6, 0, 0);
        do_write(1, 1, 1);

        // Both requesters held: grants alternate 0,1,0,1
        bus.wr_addr  = {AW'(4), AW'(3)};
        bus.wr_val   = {DW'(9), DW'(8)};
        bus.wr_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("rr_grant", 32'(bus.wr_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) begin
                check_eq("rr_ram_write", 32'(bus.ram_write), 32'd1);
                check_eq("rr_ram_a_addr", 32'(bus.ram_a_addr), (i % 2 == 1) ? 32'd3 : 32'd4);
            end
            tick();
        end
        bus.wr_valid = '0;
        #1;
        check_eq("rr_last_write", 32'(bus.ram_write), 32'd1);
        check_eq("rr_last_addr", 32'(bus.ram_a_addr), 32'd4);
        check_eq("rr_last_din", 32'(bus.ram_a_din), 32'd9);
        tick();

        // Query and writer both held: slots alternate, each response sees prior writes
        exp_map = 0;
        bus.q_val   = DW'(10);
        bus.q_valid = 1'b1;
        bus.wr_val[0 +: DW]  = DW'(10);
        bus.wr_addr[0 +: AW] = AW'(addrs[0]);
        bus.wr_valid = 2'b01;
        for (int j = 0; j < 3; j++) begin
            #1;
            check_eq("alt_q_ready", 32'(bus.q_ready), 32'd1);
            check_eq("alt_wr_blocked", 32'(bus.wr_ready), 32'd0);
            if (j > 0) begin
                check_eq("alt_ram_write", 32'(bus.ram_write), 32'd1);
                check_eq("alt_ram_a_addr", 32'(bus.ram_a_addr), 32'(addrs[j-1]));
            end
            tick();
            #1;
            check_eq("alt_rdwait_q_ready", 32'(bus.q_ready), 32'd0);
            tick();
            #1;
            check_eq("alt_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check_eq("alt_rsp_map", 32'(bus.rsp_map), 32'(exp_map));
            check_eq("alt_rsp_count", 32'(bus.rsp_count), 32'(j));
            check_eq("alt_wr_ready", 32'(bus.wr_ready), 32'd1);
            check_eq("alt_q_blocked", 32'(bus.q_ready), 32'd0);
            tick();
            exp_map = exp_map | (1 << addrs[j]);
            if (j < 2) bus.wr_addr[0 +: AW] = AW'(addrs[j+1]);
        end
        bus.q_valid  = 1'b0;
        bus.wr_valid = '0;
        #1;
        check_eq("alt_final_write", 32'(bus.ram_write), 32'd1);
        check_eq("alt_final_addr", 32'(bus.ram_a_addr), 32'd11);
        tick();
        do_query(10, 16'h0841, 3);
        do_query(8, 16'h0008, 1);
        do_query(9, 16'h0010, 1);

        // Clear beats a simultaneous query
        do_write(1, 0, 7);
        do_write(0, 15, 7);
        do_query(7, 16'h8001, 2);
        bus.clr_req = 1'b1;
        bus.q_val   = DW'(7);
        bus.q_valid = 1'b1;
        #1;
        check_eq("clr_q_blocked", 32'(bus.q_ready), 32'd0);
        check_eq("clr_idle_busy", 32'(bus.busy), 32'd0);
        tick();
        bus.clr_req = 1'b0;
        bus.q_valid = 1'b0;
        #1;
        check_eq("clr_ram_rst", 32'(bus.ram_rst), 32'd1);
        check_eq("clr_ram_write", 32'(bus.ram_write), 32'd0);
        check_eq("clr_done_early", 32'(bus.clr_done), 32'd0);
        check_eq("clr_busy", 32'(bus.busy), 32'd1);
        tick();
        #1;
        check_eq("clr_done", 32'(bus.clr_done), 32'd1);
        check_eq("clr_ram_rst_off", 32'(bus.ram_rst), 32'd0);
        do_query(7, 0, 0);
        check_eq("clr_done_pulse", 32'(bus.clr_done), 32'd0);

        // Reset while a read is outstanding
        do_write(0, 5, 12);
        do_query(12, 16'h0020, 1);
        bus.q_val   = DW'(12);
        bus.q_valid = 1'b1;
        tick();
        bus.q_valid = 1'b0;
        rst = 1'b1;
        tick();
        #1;
        check_eq("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("mid_rst_rsp_map", 32'(bus.rsp_map), 32'd0);
        check_eq("mid_rst_rsp_count", 32'(bus.rsp_count), 32'd0);
        check_eq("mid_rst_ram_rst", 32'(bus.ram_rst), 32'd1);
        check_eq("mid_rst_a_addr", 32'(bus.ram_a_addr), 32'd0);
        check_eq("mid_rst_b_din", 32'(bus.ram_b_din), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("mid_init_ram_rst", 32'(bus.ram_rst), 32'd1);
        check_eq("mid_init_busy", 32'(bus.busy), 32'd1);
        tick();
        #1;
        check_eq("mid_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("mid_idle_ram_rst", 32'(bus.ram_rst), 32'd0);
        check_eq("mid_idle_busy", 32'(bus.busy), 32'd0);
        do_query(12, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/bitmap_ram_sched.md
Name: bitmap_ram_sched

Overview:
- Scheduler and controller for the dual-port presence-bitmap RAM. Each RAM row is indexed by a data value and holds one bit per address.
- Shares the RAM between NUM_REQ write requesters (round-robin), one query client, and a clear command.
- Sequences the RAM's negedge read/write timing and returns the queried bitmap plus its popcount.
- Sits between the ingest clients and the RAM instance. It is the only driver of the RAM's rst, write, a_addr, a_din and b_din.

Parameters:
- DATA_WIDTH, 4, value width; RAM has 2**DATA_WIDTH rows.
- ADDR_WIDTH, 4, address width; each row is 2**ADDR_WIDTH bits.
- NUM_REQ, 2, number of write requesters (>=1).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- wr_valid  in  NUM_REQ  per-requester write request.
- wr_ready  out  NUM_REQ  per-requester grant; combinational, at most one bit high.
- wr_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- wr_val  in  NUM_REQ*DATA_WIDTH  packed values; same packing.
- q_valid  in  1  query request.
- q_ready  out  1  query grant; combinational.
- q_val  in  DATA_WIDTH  value (row) to query.
- rsp_valid  out  1  one-cycle response strobe; no backpressure.
- rsp_map  out  2**ADDR_WIDTH  bitmap row of the queried value.
- rsp_count  out  ADDR_WIDTH+1  popcount of rsp_map.
- clr_req  in  1  level request to clear the whole RAM.
- clr_done  out  1  one-cycle pulse when the clear is complete.
- busy  out  1  high in any state other than IDLE.
- ram_rst  out  1  to RAM rst.
- ram_write  out  1  to RAM write.
- ram_a_addr  out  ADDR_WIDTH  to RAM a_addr.
- ram_a_din  out  DATA_WIDTH  to RAM a_din.
- ram_b_din  out  DATA_WIDTH  to RAM b_din.
- ram_b_dout  in  2**ADDR_WIDTH  from RAM b_dout; updated on every negedge.

Behaviour:
- RAM interface outputs are registered. The RAM samples them on the negedge following the driving posedge.
- Reset values:
  - ram_rst=1, so the RAM clears on the negedge inside the reset cycle.
  - All other outputs 0; rr pointer=0; state=INIT.
- States:
  - INIT: ram_rst=1 for one cycle, then IDLE.
  - IDLE: arbitrates.
  - RD_WAIT: one cycle, capturing the read.
  - CLEAR: ram_rst=1 for one cycle.
- All ready outputs are 0 outside IDLE.
- IDLE priority:
  - clr_req first.
  - Then the query, unless the last granted op was a query and any wr_valid is high; in that case a write takes the slot (alternation prevents write starvation).
  - Then writes.
- Write grant:
  - Grant the lowest index >= rr pointer with wr_valid, wrapping modulo NUM_REQ.
  - Handshake occurs at a posedge with wr_valid[i] && wr_ready[i].
  - After the handshake, the next cycle drives ram_write=1, ram_a_addr=addr_i, ram_a_din=val_i for exactly one cycle. The RAM sets the bit at the following negedge.
  - rr pointer <= i+1 mod NUM_REQ.
  - Back-to-back writes are allowed, one per cycle. Duplicate writes are idempotent.
- Query:
  - Handshake at posedge k registers ram_b_din=q_val and enters RD_WAIT.
  - The RAM updates b_dout at negedge k+0.5.
  - At posedge k+1: rsp_map<=ram_b_dout, rsp_count<=popcount, rsp_valid=1 for one cycle, return to IDLE.
  - Latency is 1 cycle; throughput is one query per 2 cycles.
  - rsp_map/rsp_count hold their value until the next response.
- Read-after-write coherence:
  - A write handshaked at edge k-1 commits at negedge k-0.5, so it is visible to a query handshaked at edge k.
  - No write is driven during RD_WAIT, because the edge-k grant was the query.
- Clear:
  - Accepted in IDLE when clr_req=1. Enter CLEAR with ram_rst=1 and ram_write=0 for one cycle.
  - On exit: clr_done=1 for one cycle, return to IDLE.
  - If clr_req is still high, another clear is accepted.
- ram_write=0 in every cycle that was not preceded by a write handshake.
- Reset mid-operation:
  - An outstanding RD_WAIT is dropped; no rsp_valid.
  - Any pending write not yet driven is lost.
  - The RAM is cleared; INIT follows deassertion.

Test Plan:
- Reset, then query val 3 -> rsp_valid one cycle after handshake, rsp_map=0, rsp_count=0; busy high during INIT only.
- Req0 writes (addr 2,val 5), then (addr 9,val 5), then query val 5 -> rsp_map=0x0204, rsp_count=2; queries of val 4 and val 6 return 0.
- Both requesters hold wr_valid for 4 cycles -> grants alternate 0,1,0,1; ram_write high 4 consecutive cycles with matching addr/val.
- q_valid and wr_valid[0] held continuously -> grant sequence query, write, query, write...; every rsp_map includes all prior writes to the same value (write then immediate query of the same value returns the new bit).
- Populate val 7 with addr 0 and 15, assert clr_req together with q_valid -> clear wins (ram_rst high one cycle, clr_done pulse), then the query of val 7 returns 0.
- Assert rst during RD_WAIT -> no rsp_valid, all outputs at reset values, ram_rst=1 through the INIT cycle, later queries return 0.
